rom_write_combiner: RTL and testbench
=====================================

// Module: rom_write_combiner
//
// PURPOSE
//   Sits between the ROM download loader and the SDRAM write port. It takes byte-lane
//   writes (addr, 16-bit data, byte enables) from the loader and merges the two halves
//   of a 16-bit word into one SDRAM write. Merged writes are queued in a small FIFO,
//   which lets the loader run without stalling on every byte. A single-request handshake
//   issues the queued words to SDRAM in order.
//
// PARAMETERS
//   FIFO_DEPTH     8    Queued words awaiting SDRAM issue. Power of 2, >=2.
//   FLUSH_TIMEOUT  16   Idle cycles after the last accept before a partial word is forced out. >=1.
//
// PORTS
//   sys_clk     in   1   Sole clock.
//   reset       in   1   Synchronous, active-high.
//   flush       in   1   Force the pending (hold) word into the FIFO. Loader asserts at end of region.
//   in_addr     in   24  Word address [24:1].
//   in_data     in   16  Write data; only lanes with in_be set are meaningful.
//   in_be       in   2   Byte enables {hi,lo}; 2'b00 accepted and dropped.
//   in_valid    in   1   Write offered.
//   in_ready    out  1   High when fifo_count <= FIFO_DEPTH-1; transfer = in_valid & in_ready.
//   sdr_addr    out  24  Word address to SDRAM; stable while sdr_req=1.
//   sdr_data    out  16  Merged data; stable while sdr_req=1.
//   sdr_be      out  2   Merged byte enables; stable while sdr_req=1.
//   sdr_req     out  1   Level; held until sdr_rdy.
//   sdr_rdy     in   1   One-cycle completion pulse; ignored when sdr_req=0.
//   idle        out  1   Hold empty, FIFO empty, sdr_req=0.
//
// BEHAVIOUR
//   Reset values: in_ready=0 during reset, then 1; sdr_req=0; sdr_addr/data/be=0; idle=1;
//     hold, FIFO and timeout counter cleared. Reset mid-request drops all queued data.
//   Hold register {hv, haddr, hdata, hbe}. On each accepted transfer:
//     - hv=0: load the hold with the incoming write.
//     - hv=1, in_addr==haddr, (hbe & in_be)==0: merge. hbe |= in_be; hdata lanes replaced per in_be.
//     - otherwise (different address or overlapping lane): push the old hold to the FIFO,
//       then load the incoming write. No overwrite merges.
//   Full-word rule: if the resulting hbe==2'b11, push the hold to the FIFO in the same cycle
//     and set hv=0.
//   Push requests from flush, or when the timeout counter reaches FLUSH_TIMEOUT:
//     - They act on the post-accept hold.
//     - Deferred while the FIFO is full (hold retained).
//     - Executed the first cycle the FIFO has space.
//   Timeout counter: cleared on every accept; increments while hv=1; saturates.
//   in_ready reserves one slot, so an accept never needs to push into a full FIFO.
//   Simultaneous push and pop: FIFO count unchanged. Pointers wrap modulo FIFO_DEPTH.
//   Issue FSM:
//     - IDLE: if FIFO non-empty, latch the head into sdr_* and go to REQ.
//     - REQ: sdr_req=1; on sdr_rdy, pop the head, sdr_req=0, go to IDLE.
//     - Back-to-back words: sdr_req drops for >=1 cycle between words.
//   Latency: full-word accept at cycle N -> sdr_req=1 at N+2.
//   Ordering: SDRAM writes leave in acceptance order. The hold is always the youngest entry.
//   Address compare is the full 24 bits; no address arithmetic in this block.
//
// CONFIGURATION
//   ROM_WRITE_COMBINER_STATS_EN defined:
//     - Adds output merge_count[15:0]: accepts that merged into the hold.
//     - Adds output issue_count[15:0]: sdr_rdy completions.
//     - Both saturate at 16'hFFFF and clear on reset.
//   Undefined: the ports and counters are absent; all other behaviour is identical.
//
// TESTING
//   1. be=01 @A=0x000010 data=0x00AA, then be=10 @A data=0xBB00 -> one write: addr 0x000010,
//      data 0xBBAA, be 11; sdr_req rises 2 cycles after the 2nd accept.
//   2. be=01 @0x20, then be=01 @0x21 -> two writes, be=01 each, in order 0x20 then 0x21.
//   3. Single be=10 @0x30, no further input -> sdr_req rises after FLUSH_TIMEOUT idle cycles;
//      with flush pulsed instead, sdr_req rises 2 cycles after flush.
//   4. sdr_rdy held low; stream 2*FIFO_DEPTH+4 bytes -> in_ready drops at count=FIFO_DEPTH;
//      no word lost or reordered after sdr_rdy resumes.
//   5. Reset asserted while sdr_req=1 with 3 words queued -> next cycle sdr_req=0, idle=1;
//      later sdr_rdy pulses cause no write.
//   6. STATS_EN: test 1 gives merge_count=1, issue_count=1; test 2 gives merge_count=0, issue_count=2.

Source files
------------

// File: rtl/rom_write_combiner.sv
// Merges byte-lane loader writes into 16-bit SDRAM words, queues them and issues them in order.
// Optional statistics outputs (merge_count, issue_count) are built when ROM_WRITE_COMBINER_STATS_EN is defined.
module rom_write_combiner #(
    parameter int FIFO_DEPTH    = 8,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [23:0] in_addr,
    input  logic [15:0] in_data,
    input  logic [1:0]  in_be,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] sdr_addr,
    output logic [15:0] sdr_data,
    output logic [1:0]  sdr_be,
    output logic        sdr_req,
    input  logic        sdr_rdy,
    output logic        idle,
`ifdef ROM_WRITE_COMBINER_STATS_EN
    output logic [15:0] merge_count,
    output logic [15:0] issue_count,
`endif
    output logic        issue_state_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int UW = CW + 1;
    localparam int TW = $clog2(FLUSH_TIMEOUT + 1);

    typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

    state_t        state_q, state_d;
    logic          hv_q, hv_d, hv_p;
    logic [23:0]   haddr_q, haddr_p;
    logic [15:0]   hdata_q, hdata_p;
    logic [1:0]    hbe_q, hbe_p;
    logic          flush_pend_q, flush_pend_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [41:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [23:0]   sdr_addr_q;
    logic [15:0]   sdr_data_q;
    logic [1:0]    sdr_be_q;
    logic          acc, hit, merge, load, evict, timeout, flush_req, push_hold;
    logic          latch, pop;
    logic [UW-1:0] used;
    logic [41:0]   head;

    assign in_ready = !reset && (count_q <= CW'(FIFO_DEPTH - 1));

    // Hold update; the second FIFO write (push_hold) sees the post-accept hold.
    always_comb begin
        acc     = in_valid && in_ready;
        hit     = hv_q && (in_addr == haddr_q) && ((hbe_q & in_be) == 2'b00);
        merge   = acc && (in_be != 2'b00) && hit;
        load    = acc && (in_be != 2'b00) && !hit;
        evict   = load && hv_q;
        hv_p    = hv_q || merge || load;
        haddr_p = load ? in_addr : haddr_q;
        hbe_p   = load ? in_be : (merge ? (hbe_q | in_be) : hbe_q);
        hdata_p = load ? 16'h0000 : hdata_q;
        if ((load || merge) && in_be[0]) hdata_p[7:0]  = in_data[7:0];
        if ((load || merge) && in_be[1]) hdata_p[15:8] = in_data[15:8];
        timeout      = !acc && (tcnt_q >= TW'(FLUSH_TIMEOUT));
        flush_req    = flush || flush_pend_q;
        used         = {1'b0, count_q} + UW'(evict);
        push_hold    = hv_p && ((hbe_p == 2'b11) || flush_req || timeout)
                       && (used < UW'(FIFO_DEPTH));
        hv_d         = hv_p && !push_hold;
        flush_pend_d = flush_req && hv_p && !push_hold;
        if (acc)
            tcnt_d = '0;
        else if (hv_q && (tcnt_q != TW'(FLUSH_TIMEOUT)))
            tcnt_d = tcnt_q + TW'(1);
        else
            tcnt_d = tcnt_q;
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: if (count_q != '0) begin
                latch   = 1'b1;
                state_d = S_REQ;
            end
            S_REQ: if (sdr_rdy) begin
                pop     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (evict)     mem_q[wr_ptr_q] <= {haddr_q, hdata_q, hbe_q};
        if (push_hold) mem_q[wr_ptr_q + PW'(evict)] <= {haddr_p, hdata_p, hbe_p};
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hv_q         <= 1'b0;
            haddr_q      <= '0;
            hdata_q      <= '0;
            hbe_q        <= '0;
            flush_pend_q <= 1'b0;
            tcnt_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            sdr_addr_q   <= '0;
            sdr_data_q   <= '0;
            sdr_be_q     <= '0;
        end else begin
            state_q      <= state_d;
            hv_q         <= hv_d;
            haddr_q      <= haddr_p;
            hdata_q      <= hdata_p;
            hbe_q        <= hbe_p;
            flush_pend_q <= flush_pend_d;
            tcnt_q       <= tcnt_d;
            wr_ptr_q     <= wr_ptr_q + PW'(evict) + PW'(push_hold);
            rd_ptr_q     <= rd_ptr_q + PW'(pop);
            count_q      <= count_q + CW'(evict) + CW'(push_hold) - CW'(pop);
            if (latch) begin
                sdr_addr_q <= head[41:18];
                sdr_data_q <= head[17:2];
                sdr_be_q   <= head[1:0];
            end
        end
    end

    assign sdr_addr      = sdr_addr_q;
    assign sdr_data      = sdr_data_q;
    assign sdr_be        = sdr_be_q;
    assign sdr_req       = (state_q == S_REQ);
    assign idle          = !hv_q && (count_q == '0) && (state_q == S_IDLE);
    assign issue_state_o = state_q;

`ifdef ROM_WRITE_COMBINER_STATS_EN
    logic [15:0] merge_cnt_q, issue_cnt_q;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            merge_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            if (merge && (merge_cnt_q != 16'hFFFF)) merge_cnt_q <= merge_cnt_q + 16'd1;
            if (pop && (issue_cnt_q != 16'hFFFF))   issue_cnt_q <= issue_cnt_q + 16'd1;
        end
    end

    assign merge_count = merge_cnt_q;
    assign issue_count = issue_cnt_q;
`endif

endmodule

// File: tb/tb_rom_write_combiner.sv
// Directed bench for rom_write_combiner: merging, eviction, flush/timeout, back-pressure and reset.
module tb_rom_write_combiner;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic        sys_clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [23:0] in_addr, sdr_addr;
    logic [15:0] in_data, sdr_data;
    logic [1:0]  in_be, sdr_be;
    logic        sdr_req, sdr_rdy, idle, issue_state;
`ifdef ROM_WRITE_COMBINER_STATS_EN
    logic [15:0] merge_count, issue_count;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          write_cnt = 0;
    logic        auto_rdy = 1'b0;
    logic        force_rdy = 1'b0;
    logic [41:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;

    rom_write_combiner #(.FIFO_DEPTH(DEPTH), .FLUSH_TIMEOUT(TMO)) dut (
        .sys_clk(sys_clk), .reset(reset), .flush(flush),
        .in_addr(in_addr), .in_data(in_data), .in_be(in_be),
        .in_valid(in_valid), .in_ready(in_ready),
        .sdr_addr(sdr_addr), .sdr_data(sdr_data), .sdr_be(sdr_be),
        .sdr_req(sdr_req), .sdr_rdy(sdr_rdy), .idle(idle),
`ifdef ROM_WRITE_COMBINER_STATS_EN
        .merge_count(merge_count), .issue_count(issue_count),
`endif
        .issue_state_o(issue_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [41:0] mk(input logic [23:0] a, input logic [15:0] d,
                                       input logic [1:0] be);
        logic [15:0] m;
        m = {{8{be[1]}}, {8{be[0]}}};
        return {a, d & m, be};
    endfunction

    // Drive one write at a negedge; returns at the negedge after it was accepted.
    task automatic send(input logic [23:0] a, input logic [15:0] d, input logic [1:0] be);
        int n;
        n = 0;
        in_addr = a; in_data = d; in_be = be; in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        if (!in_ready) check("send_ready", 64'(in_ready), 64'd1);
        else @(negedge sys_clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge sys_clk);
        flush = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(idle && exp_q.size() == 0) && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        if (!(idle && exp_q.size() == 0)) check("idle_wait", 64'(exp_q.size()), 64'd0);
    endtask

    // SDRAM model: scoreboard compare at each request, then a one-cycle rdy pulse.
    initial begin
        logic [41:0] got;
        sdr_rdy = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (sdr_rdy) sdr_rdy = 1'b0;
            else if (force_rdy) sdr_rdy = 1'b1;
            else if (auto_rdy && sdr_req) begin
                got = mk(sdr_addr, sdr_data, sdr_be);
                if (exp_q.size() == 0) check("extra_write", 64'(got), 64'h0);
                else check("sdr_word", 64'(got), 64'(exp_q.pop_front()));
                sdr_rdy = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge sys_clk);
            if (sdr_req && sdr_rdy) write_cnt++;
        end
    end

    initial begin
        int wc;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_addr = '0; in_data = '0; in_be = '0;
        repeat (2) @(negedge sys_clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_sdr_req", 64'(sdr_req), 64'd0);
        check("rst_sdr_addr", 64'(sdr_addr), 64'd0);
        check("rst_sdr_data", 64'(sdr_data), 64'd0);
        check("rst_sdr_be", 64'(sdr_be), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        reset = 1'b0;
        @(negedge sys_clk);
        check("post_rst_ready", 64'(in_ready), 64'd1);
        auto_rdy = 1'b1;

        // Two halves of one word merge; request two cycles after second accept
        exp_q.push_back(mk(24'h000010, 16'hBBAA, 2'b11));
        send(24'h000010, 16'h00AA, 2'b01);
        send(24'h000010, 16'hBB00, 2'b10);
        check("t1_req_early", 64'(sdr_req), 64'd0);
        @(negedge sys_clk);
        check("t1_req_n2", 64'(sdr_req), 64'd1);
        check("t1_state", 64'(issue_state), 64'd1);
        wait_idle();
`ifdef ROM_WRITE_COMBINER_STATS_EN
        check("t1_merge_cnt", 64'(merge_count), 64'd1);
        check("t1_issue_cnt", 64'(issue_count), 64'd1);
`endif

        // Different address evicts; remaining half flushed
        exp_q.push_back(mk(24'h000020, 16'h0011, 2'b01));
        exp_q.push_back(mk(24'h000021, 16'h0022, 2'b01));
        send(24'h000020, 16'h0011, 2'b01);
        send(24'h000021, 16'h0022, 2'b01);
        pulse_flush();
        wait_idle();
`ifdef ROM_WRITE_COMBINER_STATS_EN
        check("t2_merge_cnt", 64'(merge_count), 64'd1);
        check("t2_issue_cnt", 64'(issue_count), 64'd3);
`endif

        // Overlapping lane at same address is not merged
        exp_q.push_back(mk(24'h000028, 16'h0033, 2'b01));
        exp_q.push_back(mk(24'h000028, 16'h0044, 2'b01));
        send(24'h000028, 16'h0033, 2'b01);
        send(24'h000028, 16'h0044, 2'b01);
        pulse_flush();
        wait_idle();

        // Empty byte enables dropped; full word goes straight out
        exp_q.push_back(mk(24'h00002A, 16'h7788, 2'b11));
        send(24'h000029, 16'h5566, 2'b00);
        send(24'h00002A, 16'h7788, 2'b11);
        wait_idle();

        // Timeout pushes a lone half word
        exp_q.push_back(mk(24'h000030, 16'hCC00, 2'b10));
        send(24'h000030, 16'hCC00, 2'b10);
        repeat (TMO + 1) @(negedge sys_clk);
        check("t3_tmo_early", 64'(sdr_req), 64'd0);
        @(negedge sys_clk);
        check("t3_tmo_req", 64'(sdr_req), 64'd1);
        wait_idle();

        // Flush pushes a lone half word
        exp_q.push_back(mk(24'h000031, 16'hDD00, 2'b10));
        send(24'h000031, 16'hDD00, 2'b10);
        flush = 1'b1;
        @(negedge sys_clk);
        flush = 1'b0;
        check("t3_flush_early", 64'(sdr_req), 64'd0);
        @(negedge sys_clk);
        check("t3_flush_req", 64'(sdr_req), 64'd1);
        wait_idle();

        // Back-pressure with SDRAM stalled, then drain in order
        auto_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(mk(24'h000100 + 24'(i), {8'(8'h40 + i), 8'(i + 1)}, 2'b11));
            send(24'h000100 + 24'(i), {8'h00, 8'(i + 1)}, 2'b01);
            send(24'h000100 + 24'(i), {8'(8'h40 + i), 8'h00}, 2'b10);
            if (i == 6) check("t4_ready_7", 64'(in_ready), 64'd1);
            if (i == 7) begin
                check("t4_ready_full", 64'(in_ready), 64'd0);
                auto_rdy = 1'b1;
            end
        end
        wait_idle();

        // Reset during an active request drops everything
        auto_rdy = 1'b0;
        send(24'h000200, 16'h1111, 2'b11);
        send(24'h000201, 16'h2222, 2'b11);
        send(24'h000202, 16'h3333, 2'b11);
        repeat (2) @(negedge sys_clk);
        check("t5_req_before", 64'(sdr_req), 64'd1);
        wc = write_cnt;
        reset = 1'b1;
        @(negedge sys_clk);
        check("t5_req_rst", 64'(sdr_req), 64'd0);
        check("t5_idle_rst", 64'(idle), 64'd1);
        check("t5_ready_rst", 64'(in_ready), 64'd0);
        reset = 1'b0;
        force_rdy = 1'b1;
        repeat (6) @(negedge sys_clk);
        force_rdy = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("t5_req_after", 64'(sdr_req), 64'd0);
        check("t5_no_write", 64'(write_cnt), 64'(wc));
        check("t5_idle_after", 64'(idle), 64'd1);
        check("t5_ready_after", 64'(in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
